// File: rtl/keccak_byte_padder.sv
// ---------------------------------------------------------------------------
// keccak_byte_padder
//
// Front end of the Keccak hash core. Message bytes arrive one per beat and
// are packed into RATE_BYTES-byte rate blocks. The final block of a message
// gets Keccak multi-rate padding (PAD_FIRST after the last message byte,
// PAD_LAST ORed into the last byte of the block). Each finished block is
// offered to the permutation, which consumes it by pulsing f_ack.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high; clears all state
//   in_byte    in   [7:0] message byte
//   in_valid   in   beat offered
//   in_last    in   beat is the last of the message
//   in_empty   in   beat carries no byte (end marker / zero-length message)
//   in_ready   out  beat accepted when in_valid & in_ready
//   out        out  [8*RATE_BYTES-1:0] block, byte 0 in the top byte lane
//   out_ready  out  block valid (permutation in_ready)
//   out_last   out  block is the final padded block of the message
//   f_ack      in   permutation consumed out this cycle
//
// RATE_BYTES must be at least 2 (the pad-only block needs distinct first
// and last byte lanes).
// ---------------------------------------------------------------------------
module keccak_byte_padder #(
  parameter int unsigned RATE_BYTES = 72,
  parameter logic [7:0]  PAD_FIRST  = 8'h01,
  parameter logic [7:0]  PAD_LAST   = 8'h80
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_byte,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic                    in_empty,
  output logic                    in_ready,
  output logic [8*RATE_BYTES-1:0] out,
  output logic                    out_ready,
  output logic                    out_last,
  input  logic                    f_ack
);

  localparam int unsigned BW = 8 * RATE_BYTES;
  localparam int unsigned CW = $clog2(RATE_BYTES + 1);
  localparam logic [CW-1:0] LAST_POS = CW'(RATE_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RATE_BYTES);

  // Block that follows a message whose length is an exact multiple of the rate.
  localparam logic [BW-1:0] PAD_BLK = {PAD_FIRST, {(BW - 16){1'b0}}, PAD_LAST};

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_FULL   = 2'd1,
    S_PADBLK = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   buf_q;
  logic            out_last_q;
  logic            pad_pending_q;

  logic            accept_s;
  logic            data_en_s;
  logic            pad_now_s;
  logic [CW-1:0]   len_s;
  logic [BW-1:0]   written_s;
  logic [BW-1:0]   padded_s;

  // Bit offset of byte lane 'pos'; byte 0 sits in the most significant lane.
  function automatic int unsigned byte_lsb(input logic [CW-1:0] pos);
    return (RATE_BYTES - 1 - 32'(pos)) * 8;
  endfunction

  // Next buffer contents for a FILL-state beat: write the byte, then pad if last.
  always_comb begin
    accept_s  = in_valid & (state_q == S_FILL);
    data_en_s = accept_s & ~in_empty;
    len_s     = cnt_q + CW'(data_en_s);
    // Padding fits in this block only while the message leaves a free lane.
    pad_now_s = accept_s & in_last & (len_s < FULL_CNT);

    written_s = buf_q;
    if (data_en_s) begin
      written_s[byte_lsb(cnt_q) +: 8] = in_byte;
    end else begin
      written_s = buf_q;
    end

    padded_s = written_s;
    if (pad_now_s) begin
      // ORing handles the p = RATE_BYTES-1 case, where both pads share a lane.
      padded_s[byte_lsb(len_s) +: 8] = padded_s[byte_lsb(len_s) +: 8] | PAD_FIRST;
      padded_s[7:0]                  = padded_s[7:0] | PAD_LAST;
    end else begin
      padded_s = written_s;
    end
  end

  // Control FSM plus block buffer; all outputs come from these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      buf_q         <= '0;
      out_last_q    <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept_s) begin
            buf_q <= padded_s;
            if (in_last) begin
              state_q       <= S_FULL;
              cnt_q         <= '0;
              out_last_q    <= (len_s < FULL_CNT);
              pad_pending_q <= (len_s == FULL_CNT);
            end else if (data_en_s && (cnt_q == LAST_POS)) begin
              state_q    <= S_FULL;
              cnt_q      <= '0;
              out_last_q <= 1'b0;
            end else begin
              cnt_q <= len_s;
            end
          end
        end
        S_FULL: begin
          if (f_ack) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            out_last_q <= 1'b0;
            state_q    <= pad_pending_q ? S_PADBLK : S_FILL;
          end
        end
        S_PADBLK: begin
          buf_q         <= PAD_BLK;
          pad_pending_q <= 1'b0;
          out_last_q    <= 1'b1;
          state_q       <= S_FULL;
        end
        default: begin
          state_q       <= S_FILL;
          cnt_q         <= '0;
          buf_q         <= '0;
          out_last_q    <= 1'b0;
          pad_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign out_ready = (state_q == S_FULL);
  assign out_last  = out_last_q;
  assign out       = buf_q;

endmodule

// File: tb/tb_keccak_byte_padder.sv
// ---------------------------------------------------------------------------
// tb_keccak_byte_padder
//
// Directed bench for keccak_byte_padder with the default 72-byte rate.
// Expected blocks come from a padded copy of each message (message, 0x01,
// zeros up to a block multiple, last byte ORed with 0x80) and from
// hand-written literals for the final block of each directed case.
// ---------------------------------------------------------------------------
module tb_keccak_byte_padder;

  logic         clk;
  logic         reset;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [575:0] out;
  logic         out_ready;
  logic         out_last;
  logic         f_ack;

  int n_cmp;
  int n_fail;

  logic [7:0]   msg   [$];
  logic [7:0]   pad_q [$];
  logic [575:0] hand;

  keccak_byte_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .in_ready  (in_ready),
    .out       (out),
    .out_ready (out_ready),
    .out_last  (out_last),
    .f_ack     (f_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] b, input logic last, input logic empty);
    chk1("in_ready_before_beat", in_ready, 1'b1);
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    in_empty = empty;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Checks the presented block b, holds it for 'delay' cycles, then acks it.
  task automatic check_block(input int b, input int nblk, input int len, input int delay,
                             input bit use_hand, input logic [575:0] hand_last,
                             input string tag);
    logic [575:0] exp;
    exp = '0;
    for (int k = 0; k < 72; k++) begin
      exp[(71 - k) * 8 +: 8] = pad_q[b * 72 + k];
    end
    chk1($sformatf("%s b%0d out_ready", tag, b), out_ready, 1'b1);
    chk1($sformatf("%s b%0d out_last", tag, b), out_last, (b == nblk - 1));
    chk1($sformatf("%s b%0d in_ready_low", tag, b), in_ready, 1'b0);
    chkv($sformatf("%s b%0d out", tag, b), out, exp);
    if (use_hand && (b == nblk - 1)) begin
      chkv($sformatf("%s b%0d hand", tag, b), out, hand_last);
    end
    for (int d = 0; d < delay; d++) begin
      step();
      chkv($sformatf("%s b%0d hold%0d out", tag, b, d), out, exp);
      chk1($sformatf("%s b%0d hold%0d in_ready", tag, b, d), in_ready, 1'b0);
      chk1($sformatf("%s b%0d hold%0d out_ready", tag, b, d), out_ready, 1'b1);
    end
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk1($sformatf("%s b%0d out_ready_after_ack", tag, b), out_ready, 1'b0);
    if ((b == nblk - 2) && (len == (nblk - 1) * 72)) begin
      chk1($sformatf("%s b%0d in_ready_padblk", tag, b), in_ready, 1'b0);
    end else begin
      chk1($sformatf("%s b%0d in_ready_after_ack", tag, b), in_ready, 1'b1);
    end
  endtask

  // Sends the whole message in 'msg' and checks every resulting block.
  task automatic run_msg(input int delay, input bit use_hand, input logic [575:0] hand_last,
                         input string tag);
    int len;
    int nblk;
    int blk;
    len  = msg.size();
    nblk = len / 72 + 1;
    pad_q.delete();
    for (int i = 0; i < len; i++) pad_q.push_back(msg[i]);
    pad_q.push_back(8'h01);
    while (pad_q.size() < nblk * 72) pad_q.push_back(8'h00);
    pad_q[nblk * 72 - 1] = pad_q[nblk * 72 - 1] | 8'h80;
    blk = 0;
    if (len == 0) begin
      send_beat(8'h00, 1'b1, 1'b1);
      check_block(0, nblk, len, delay, use_hand, hand_last, tag);
      blk = 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        send_beat(msg[i], (i == len - 1), 1'b0);
        if ((i % 72 == 71) || (i == len - 1)) begin
          check_block(blk, nblk, len, delay, use_hand, hand_last, tag);
          blk++;
        end
      end
    end
    if (blk < nblk) begin
      // Pad-only block reappears two cycles after the ack.
      step();
      check_block(blk, nblk, len, delay, use_hand, hand_last, tag);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
    f_ack    = 1'b0;
    step();
    step();

    // Reset state
    chk1("rst in_ready", in_ready, 1'b1);
    chk1("rst out_ready", out_ready, 1'b0);
    chk1("rst out_last", out_last, 1'b0);
    chkv("rst out", out, 576'b0);
    reset = 1'b0;
    step();

    // Stray f_ack and in_last without in_valid are ignored
    f_ack   = 1'b1;
    in_last = 1'b1;
    step();
    f_ack   = 1'b0;
    in_last = 1'b0;
    step();
    chk1("ignored in_ready", in_ready, 1'b1);
    chk1("ignored out_ready", out_ready, 1'b0);
    chkv("ignored out", out, 576'b0);

    // Zero-length message
    msg.delete();
    hand = {8'h01, 560'b0, 8'h80};
    run_msg(0, 1'b1, hand, "zero");

    // "abc"
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
    hand = {32'h61626301, 536'b0, 8'h80};
    run_msg(2, 1'b1, hand, "abc");

    // 71 bytes 00..46: both pads share the final lane
    msg.delete();
    hand = '0;
    for (int i = 0; i < 71; i++) begin
      msg.push_back(8'(i));
      hand[(71 - i) * 8 +: 8] = 8'(i);
    end
    hand[7:0] = 8'h81;
    run_msg(0, 1'b1, hand, "len71");

    // 72 bytes 00..47: full block then pad-only block
    msg.delete();
    for (int i = 0; i < 72; i++) msg.push_back(8'(i));
    hand = {8'h01, 560'b0, 8'h80};
    run_msg(1, 1'b1, hand, "len72");

    // 150 bytes with a 5-cycle permutation wait per block
    msg.delete();
    for (int i = 0; i < 150; i++) msg.push_back(8'(i));
    hand = {48'h909192939495, 8'h01, 512'b0, 8'h80};
    run_msg(5, 1'b1, hand, "len150");

    // Abort after 10 bytes, then "abc" must come out clean
    for (int i = 0; i < 10; i++) send_beat(8'hA0 + 8'(i), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk1("abort in_ready", in_ready, 1'b1);
    chk1("abort out_ready", out_ready, 1'b0);
    chkv("abort out", out, 576'b0);
    step();
    reset = 1'b0;
    step();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
    hand = {32'h61626301, 536'b0, 8'h80};
    run_msg(0, 1'b1, hand, "abc_after_reset");

    // Reset during FULL discards the waiting block
    msg.delete();
    for (int i = 0; i < 72; i++) send_beat(8'h11, 1'b0, 1'b0);
    chk1("fullabort out_ready_pre", out_ready, 1'b1);
    reset = 1'b1;
    #1;
    chk1("fullabort out_ready", out_ready, 1'b0);
    chk1("fullabort in_ready", in_ready, 1'b1);
    chkv("fullabort out", out, 576'b0);
    step();
    reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
